frame_draw_scheduler: RTL and testbench

- Per-frame draw sequencer for the game screen. Sits between the game FSM and the VGA adapter.
- Each frame it enables mouse tracking, then runs the catcher, meatsquare and score drawers in turn through their draw/finish_drawing handshake.
- It multiplexes the active drawer's x/y/color onto a single plot stream for the VGA adapter.

---
 rtl/frame_draw_scheduler_pkg.sv | 22 ++
 rtl/frame_draw_scheduler_tick.sv | 29 ++
 rtl/frame_draw_scheduler.sv | 156 +++++++++++++++
 tb/tb_frame_draw_scheduler.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_draw_scheduler_pkg.sv
// Shared types and constants for the per-frame draw scheduler.
package frame_draw_scheduler_pkg;

    // Sequencer states; ARM/DRAW/GAP are visited once per client, in order.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        DRAW = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Client indices; the draw order is fixed and follows these values.
    localparam int CLIENT_CATCHER = 0;
    localparam int CLIENT_MEAT    = 1;
    localparam int CLIENT_SCORE   = 2;

    // Visible game area in pixels.
    localparam int SCREEN_W = 120;
    localparam int SCREEN_H = 120;

endpackage

// File: rtl/frame_draw_scheduler_tick.sv
// Frame period counter: free-running while the game runs, held at 0 otherwise.
module frame_tick_gen #(
    parameter int FRAME_TICKS = 833333
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int CW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

    logic [CW-1:0] count;

    assign tick = (count == CW'(FRAME_TICKS - 1));

    // Count 0..FRAME_TICKS-1 and wrap; a stopped game parks the count at 0.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset || !run) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/frame_draw_scheduler.sv
// Per-frame draw sequencer: arms each drawer in turn and funnels its pixels to the VGA adapter.
module frame_draw_scheduler
    import frame_draw_scheduler_pkg::*;
#(
    parameter int FRAME_TICKS    = 833333,
    parameter int N_CLIENTS      = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run,
    input  logic [N_CLIENTS-1:0]   finish_in,
    input  logic [8*N_CLIENTS-1:0] x_in,
    input  logic [7*N_CLIENTS-1:0] y_in,
    input  logic [3*N_CLIENTS-1:0] color_in,
    output logic [N_CLIENTS-1:0]   draw_req,
    output logic                   enable_tracking,
    output logic [7:0]             x,
    output logic [6:0]             y,
    output logic [2:0]             color,
    output logic                   plot,
    output logic                   frame_done,
    output logic                   overrun,
    output logic                   timeout_err
);

    localparam int KW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;
    localparam int WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t        state_q, state_d;
    logic [KW-1:0] idx_q, idx_d;
    logic [WW-1:0] wd_q;
    logic          tick;
    logic          plot_d;
    logic          abort;

    // Per-client views of the packed drawer buses.
    logic [N_CLIENTS-1:0][7:0] x_arr;
    logic [N_CLIENTS-1:0][6:0] y_arr;
    logic [N_CLIENTS-1:0][2:0] color_arr;

    assign x_arr     = x_in;
    assign y_arr     = y_in;
    assign color_arr = color_in;

    frame_tick_gen #(
        .FRAME_TICKS(FRAME_TICKS)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .run  (run),
        .tick (tick)
    );

    // Next-state and Moore outputs of the client sequencer.
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        draw_req   = '0;
        frame_done = 1'b0;
        plot_d     = 1'b0;
        abort      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick && run) begin
                    idx_d   = '0;
                    state_d = ARM;
                end
            end
            ARM: begin
                draw_req = N_CLIENTS'(1) << idx_q;
                state_d  = DRAW;
            end
            DRAW: begin
                draw_req = N_CLIENTS'(1) << idx_q;
                if (finish_in[idx_q]) begin
                    // A finish on the expiry cycle still counts as a clean finish.
                    state_d = GAP;
                end else begin
                    plot_d = 1'b1;
                    if (wd_q == WW'(TIMEOUT_CYCLES - 1)) begin
                        abort   = 1'b1;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (idx_q == KW'(N_CLIENTS - 1)) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + KW'(1);
                    state_d = ARM;
                end
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state, client index and the tracking enable (low whenever a drawer is armed).
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            enable_tracking <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            enable_tracking <= (state_d == IDLE) && run;
        end
    end

    // Watchdog: restarts on arm, counts every cycle the drawer holds the bus.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wd_q <= '0;
        end else if (state_q == ARM) begin
            wd_q <= '0;
        end else if (state_q == DRAW) begin
            wd_q <= wd_q + WW'(1);
        end
    end

    // Pixel stage: capture the active drawer's output; plot only pixels produced in response to draw.
    always_ff @(posedge clock) begin
        if (!reset) begin
            x     <= '0;
            y     <= '0;
            color <= '0;
            plot  <= 1'b0;
        end else begin
            plot <= plot_d;
            if (state_q == ARM || state_q == DRAW) begin
                x     <= x_arr[idx_q];
                y     <= y_arr[idx_q];
                color <= color_arr[idx_q];
            end
        end
    end

    // Sticky error flags: missed frame tick and aborted drawer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (tick && state_q != IDLE) overrun <= 1'b1;
            if (abort) timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Scoreboard bench for frame_draw_scheduler with three registered drawer models.
module tb_frame_draw_scheduler;
    import frame_draw_scheduler_pkg::*;

    localparam int FT = 500;
    localparam int TO = 400;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic [2:0]  finish_in;
    logic [23:0] x_in;
    logic [20:0] y_in;
    logic [8:0]  color_in;
    logic [2:0]  draw_req;
    logic        enable_tracking;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  color;
    logic        plot;
    logic        frame_done;
    logic        overrun;
    logic        timeout_err;

    frame_draw_scheduler #(
        .FRAME_TICKS   (FT),
        .N_CLIENTS     (3),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .run            (run),
        .finish_in      (finish_in),
        .x_in           (x_in),
        .y_in           (y_in),
        .color_in       (color_in),
        .draw_req       (draw_req),
        .enable_tracking(enable_tracking),
        .x              (x),
        .y              (y),
        .color          (color),
        .plot           (plot),
        .frame_done     (frame_done),
        .overrun        (overrun),
        .timeout_err    (timeout_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- drawer models ----------------
    // Each drawer registers one pixel per cycle while draw is high, then pulses finish
    // once after mlen pixels (never, if hang is set).
    int         mlen [3];
    int         mcnt [3];
    int         ybase [3];
    logic [2:0] hang;
    logic [2:0] stray;
    logic [2:0] mfin;
    logic [2:0] mvalid;
    logic [7:0] mx [3];
    logic [6:0] my [3];

    assign finish_in = mfin | stray;
    assign x_in      = {mx[2], mx[1], mx[0]};
    assign y_in      = {my[2], my[1], my[0]};
    assign color_in  = {3'd3, 3'd2, 3'd1};

    always @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (!reset || !draw_req[k]) begin
                mcnt[k]   <= 0;
                mvalid[k] <= 1'b0;
                mfin[k]   <= 1'b0;
            end else if (!hang[k] && mcnt[k] >= mlen[k]) begin
                mfin[k]   <= (mcnt[k] == mlen[k]);
                mvalid[k] <= 1'b0;
                mcnt[k]   <= mcnt[k] + 1;
            end else begin
                mx[k]     <= 8'(mcnt[k] % (SCREEN_W - 1));
                my[k]     <= 7'(ybase[k] + mcnt[k] / (SCREEN_W - 1));
                mvalid[k] <= 1'b1;
                mfin[k]   <= 1'b0;
                mcnt[k]   <= mcnt[k] + 1;
            end
        end
    end

    // ---------------- checking ----------------
    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     tag, actual, actual, expected, expected, cyc);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [31:0] sb_q [$];
    int          start_at [$];
    int          draw_hi [3];
    int          plots [3];
    logic [14:0] first_xy [3];
    int          done_cnt;
    int          cur_k = 0;
    int          gap_len = 0;
    logic [2:0]  prev_req = '0;
    int          onehot_err = 0;
    int          track_err = 0;
    int          gap_err = 0;
    int          order_err = 0;

    initial begin
        forever begin
            @(negedge clock);
            if (!reset) begin
                sb_q.delete();
                prev_req = '0;
                gap_len  = 0;
            end else begin
                if (plot) begin
                    if (sb_q.size() == 0) begin
                        check("sb_depth_at_plot", 32'(sb_q.size()), 1);
                    end else begin
                        logic [31:0] exp_px;
                        exp_px = sb_q.pop_front();
                        check("pixel", {14'd0, x, y, color}, exp_px);
                    end
                    if (plots[cur_k] == 0) first_xy[cur_k] = {x, y};
                    plots[cur_k]++;
                end
                if (!$onehot0(draw_req)) onehot_err++;
                if (enable_tracking && draw_req != 3'b000) track_err++;
                if (frame_done) done_cnt++;
                if (draw_req != 3'b000) begin
                    int k_now = 0;
                    for (int k = 0; k < 3; k++) if (draw_req[k]) k_now = k;
                    draw_hi[k_now]++;
                    if (prev_req == 3'b000) begin
                        if (k_now == 0) begin
                            start_at.push_back(cyc);
                        end else begin
                            if (gap_len != 1) gap_err++;
                            if (k_now != cur_k + 1) order_err++;
                        end
                    end else if (prev_req != draw_req) begin
                        gap_err++;
                    end
                    cur_k   = k_now;
                    gap_len = 0;
                end else begin
                    gap_len++;
                end
                // A pixel on the bus while its drawer is armed must appear on the next cycle.
                for (int k = 0; k < 3; k++) begin
                    if (draw_req[k] && mvalid[k])
                        sb_q.push_back({14'd0, mx[k], my[k], 3'(k + 1)});
                end
                prev_req = draw_req;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 3; k++) begin
            draw_hi[k]  = 0;
            plots[k]    = 0;
            first_xy[k] = '0;
        end
        done_cnt = 0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n    = 0;
        int base = done_cnt;
        while (done_cnt == base && n < budget) begin
            step();
            n++;
        end
        check({tag, "_frame_done_seen"}, 32'(done_cnt != base), 1);
    endtask

    task automatic wait_req(input string tag, input logic [2:0] val, input int budget);
        int n = 0;
        while (draw_req !== val && n < budget) begin
            step();
            n++;
        end
        check({tag, "_draw_req_reached"}, 32'(draw_req === val), 1);
    endtask

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        repeat (30000) @(posedge clock);
        $display("FAIL global_time_limit: cycle %0d reached, limit 30000", cyc);
        $fatal(1, "time limit");
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int n;
        reset = 1'b0;
        run   = 1'b1;
        stray = '0;
        hang  = '0;
        ybase[CLIENT_CATCHER] = SCREEN_H - 8;
        ybase[CLIENT_MEAT]    = 20;
        ybase[CLIENT_SCORE]   = 40;
        for (int k = 0; k < 3; k++) begin
            mx[k] = '0;
            my[k] = '0;
        end
        mlen = '{357, 19, 19};
        clear_stats();

        // Reset state
        repeat (3) step();
        check("rst_draw_req", 32'(draw_req), 0);
        check("rst_pixel_path", {13'd0, plot, x, y, color}, 0);
        check("rst_flags", {28'd0, frame_done, overrun, timeout_err, enable_tracking}, 0);
        reset = 1'b1;
        step();
        step();
        check("idle_tracking", 32'(enable_tracking), 1);

        // Frame 1: catcher draws three rows, other drawers 19 pixels each
        clear_stats();
        wait_done("f1", 2000);
        check("f1_c0_req_cycles", draw_hi[0], 359);
        check("f1_c0_plots", plots[0], 357);
        check("f1_c0_first_xy", 32'(first_xy[0]), {17'd0, 8'd0, 7'(SCREEN_H - 8)});
        check("f1_c1_req_cycles", draw_hi[1], 21);
        check("f1_c1_plots", plots[1], 19);
        check("f1_c2_plots", plots[2], 19);
        check("f1_done_pulses", done_cnt, 1);
        check("f1_flags", {30'd0, overrun, timeout_err}, 0);
        step();
        step();
        check("f1_idle_tracking", 32'(enable_tracking), 1);

        // Frame 2: meatsquare drawer hangs and is aborted; stray finishes are ignored
        mlen = '{19, 0, 19};
        hang = 3'b010;
        clear_stats();
        wait_req("f2_meat", 3'b010, 700);
        repeat (30) step();
        stray = 3'b101;
        step();
        stray = '0;
        wait_done("f2", 1500);
        check("f2_c1_req_cycles", draw_hi[1], TO + 1);
        check("f2_c1_plots", plots[1], TO);
        check("f2_timeout_err", 32'(timeout_err), 1);
        check("f2_c2_plots", plots[2], 19);
        check("f2_done_pulses", done_cnt, 1);
        check("f2_overrun", 32'(overrun), 0);

        // Frames 3/4: drawing outlasts the frame period, one tick is skipped
        hang = '0;
        mlen = '{200, 200, 200};
        clear_stats();
        base = start_at.size();
        n    = 0;
        while (start_at.size() < base + 2 && n < 3000) begin
            step();
            n++;
        end
        check("f3_two_starts", 32'(start_at.size() >= base + 2), 1);
        if (start_at.size() >= base + 2) begin
            check("f3_normal_interval", start_at[base] - start_at[base - 1], FT);
            check("f3_skipped_interval", start_at[base + 1] - start_at[base], 2 * FT);
        end
        check("f3_overrun", 32'(overrun), 1);
        check("f3_done_pulses", done_cnt, 1);

        // Reset in the middle of DRAW(1)
        wait_req("f4_meat", 3'b010, 800);
        repeat (10) step();
        reset = 1'b0;
        step();
        check("rst_mid_draw_req", 32'(draw_req), 0);
        check("rst_mid_plot", 32'(plot), 0);
        check("rst_mid_flags", {30'd0, overrun, timeout_err}, 0);
        step();
        reset = 1'b1;
        step();
        step();
        check("rst_mid_idle_tracking", 32'(enable_tracking), 1);
        check("rst_mid_idle_req", 32'(draw_req), 0);

        // run low: no frames at all
        run = 1'b0;
        clear_stats();
        repeat (1200) step();
        check("stopped_req_cycles", draw_hi[0] + draw_hi[1] + draw_hi[2], 0);
        check("stopped_done", done_cnt, 0);
        check("stopped_tracking", 32'(enable_tracking), 0);

        // run drops during DRAW(0); finish coincides with watchdog expiry for the catcher
        mlen = '{TO - 1, 19, 19};
        run  = 1'b1;
        clear_stats();
        wait_req("f5_catcher", 3'b001, 700);
        repeat (50) step();
        run = 1'b0;
        wait_done("f5", 1500);
        check("f5_c0_plots", plots[0], TO - 1);
        check("f5_c0_req_cycles", draw_hi[0], TO + 1);
        check("f5_finish_beats_timeout", 32'(timeout_err), 0);
        check("f5_c1_plots", plots[1], 19);
        check("f5_c2_plots", plots[2], 19);
        clear_stats();
        repeat (1200) step();
        check("f5_no_more_frames", draw_hi[0] + draw_hi[1] + draw_hi[2], 0);
        check("f5_no_more_done", done_cnt, 0);

        // Invariants collected over the whole run
        check("inv_onehot", onehot_err, 0);
        check("inv_tracking_while_drawing", track_err, 0);
        check("inv_one_cycle_gaps", gap_err, 0);
        check("inv_client_order", order_err, 0);
        check("sb_drained", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
